// File: rtl/systolic_row_skewer_pkg.sv
// Shared types and default geometry for the systolic front end.
// The row depth matches the 16-row depth of the blocking buffer slaves.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skewer_state_t;

  localparam int SA_ELEM_W  = 8;
  localparam int SA_N_LANES = 8;
  localparam int SA_N_ROWS  = 16;

endpackage

// File: rtl/systolic_row_skewer_if.sv
// Row stream in from the buffer and skewed lane data out to the array.
interface systolic_row_skewer_if
  import systolic_pkg::*;
#(
  parameter int ELEM_W  = SA_ELEM_W,
  parameter int N_LANES = SA_N_LANES
);
  logic                      row_valid;
  logic [ELEM_W*N_LANES-1:0] row_data;
  logic                      row_ready;
  logic [ELEM_W*N_LANES-1:0] sa_data;
  logic [N_LANES-1:0]        sa_lane_valid;

  modport master (output row_valid, row_data, input row_ready, sa_data, sa_lane_valid);
  modport slave  (input row_valid, row_data, output row_ready, sa_data, sa_lane_valid);
endinterface

// File: rtl/systolic_row_skewer_delay.sv
// Valid+data shift register of DEPTH stages with synchronous clear.
// Data is zeroed whenever its valid is low so no stale value ever reaches the output.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);
  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] dat_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      dat_q[0] <= vld_i ? dat_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/systolic_row_skewer.sv
// Skews each accepted row into a diagonal wavefront (lane k delayed k cycles),
// counts rows per tile, drains after the last row and pulses tile completion.
module systolic_row_skewer
  import systolic_pkg::*;
#(
  parameter int ELEM_W  = SA_ELEM_W,
  parameter int N_LANES = SA_N_LANES,
  parameter int N_ROWS  = SA_N_ROWS
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  systolic_row_skewer_if.slave bus,
  output logic                 tile_done_o,
  output logic                 busy_o,
  output logic                 overflow_o
);
  localparam int RW = $clog2(N_ROWS + 1);
  localparam int DW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  skewer_state_t state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          ready, accept, last_row;
  logic [N_LANES-1:0] done_q;
  logic          overflow_q;

  assign ready    = (state_q != DRAIN);
  // flush wins over a concurrent row: the row is not taken into the pipeline
  assign accept   = bus.row_valid & ready & ~flush_i;
  assign last_row = accept && (row_cnt_q == RW'(N_ROWS - 1));

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (flush_i) begin
      state_d     = IDLE;
      row_cnt_d   = '0;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (last_row) begin
              row_cnt_d = '0;
              if (N_LANES > 1) begin
                state_d     = DRAIN;
                drain_cnt_d = DW'(N_LANES - 1);
              end else begin
                state_d = IDLE;
              end
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
              state_d   = STREAM;
            end
          end
        end
        DRAIN: begin
          drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q == DW'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      done_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      overflow_q  <= overflow_q | (bus.row_valid & ~ready);
      if (flush_i) begin
        done_q <= '0;
      end else begin
        // tile marker travels alongside the last lane so the pulse lines up with it
        done_q[0] <= last_row;
        for (int i = 1; i < N_LANES; i++) done_q[i] <= done_q[i-1];
      end
    end
  end

  logic [N_LANES-1:0]             lane_vld;
  logic [N_LANES-1:0][ELEM_W-1:0] lane_dat;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    skew_delay_line #(.DEPTH(k + 1), .W(ELEM_W)) u_dl (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clr_i  (flush_i),
      .vld_i  (accept),
      .dat_i  (bus.row_data[k*ELEM_W +: ELEM_W]),
      .vld_o  (lane_vld[k]),
      .dat_o  (lane_dat[k])
    );
  end

  assign bus.row_ready     = ready;
  assign bus.sa_data       = lane_dat;
  assign bus.sa_lane_valid = lane_vld;
  assign tile_done_o       = done_q[N_LANES-1];
  assign busy_o            = (state_q != IDLE) | (|lane_vld);
  assign overflow_o        = overflow_q;
endmodule

// File: tb/tb_systolic_row_skewer.sv
// Directed bench: stimulus pushes expected lane elements and tile-done edges into
// queues; a negedge monitor pops and compares whatever the skewer presents.
module tb_systolic_row_skewer;
  import systolic_pkg::*;

  localparam int EW = 8;
  localparam int NL = 8;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic tile_done, busy, ovf;
  int   ecnt = 0;
  int   ntest = 0;
  int   nfail = 0;

  typedef struct {
    logic [EW-1:0] d;
    int            c;
  } exp_t;

  exp_t lq[NL][$];
  int   dq[$];

  systolic_row_skewer_if #(.ELEM_W(EW), .N_LANES(NL)) bus ();

  systolic_row_skewer #(.ELEM_W(EW), .N_LANES(NL), .N_ROWS(NR)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .bus        (bus),
    .tile_done_o(tile_done),
    .busy_o     (busy),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.row_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_exp();
    for (int k = 0; k < NL; k++) lq[k].delete();
    dq.delete();
  endtask

  // Row r of a tile: lane k = {r ^ tag, k}; accepted on the coming edge ecnt+1.
  task automatic put_row(input int r, input logic [3:0] tag);
    exp_t e;
    bus.row_valid = 1'b1;
    for (int k = 0; k < NL; k++) begin
      e.d = {4'(r) ^ tag, 4'(k)};
      e.c = ecnt + 1 + k;
      bus.row_data[k*EW +: EW] = e.d;
      lq[k].push_back(e);
    end
    if (r == NR - 1) dq.push_back(ecnt + NL);
    step();
  endtask

  // Called right after the last row's accept edge: ready must be low for NL-1 cycles.
  task automatic drain_check(input bit hold);
    for (int i = 0; i < NL - 1; i++) begin
      chk("ready_low_in_drain", bus.row_ready, 1'b0);
      if (hold && i > 0) chk("overflow_set", ovf, 1'b1);
      bus.row_valid = hold;
      if (hold) bus.row_data = {NL{8'hEE}};
      step();
    end
    bus.row_valid = 1'b0;
    chk("ready_back_high", bus.row_ready, 1'b1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NL; k++) begin
      if (bus.sa_lane_valid[k]) begin
        if (lq[k].size() == 0) begin
          chk($sformatf("lane%0d_unexpected", k), bus.sa_lane_valid[k], 1'b0);
        end else begin
          e = lq[k].pop_front();
          chk($sformatf("lane%0d_data", k), bus.sa_data[k*EW +: EW], e.d);
          chk($sformatf("lane%0d_cycle", k), ecnt, e.c);
        end
      end else begin
        chk($sformatf("lane%0d_idle_zero", k), bus.sa_data[k*EW +: EW], '0);
      end
    end
    if (tile_done) begin
      if (dq.size() == 0) chk("done_unexpected", tile_done, 1'b0);
      else chk("done_cycle", ecnt, dq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    #12;
    chk("rst_ready", bus.row_ready, 1'b1);
    chk("rst_lane_valid", bus.sa_lane_valid, '0);
    chk("rst_data", bus.sa_data, '0);
    chk("rst_done", tile_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // plain tile
    for (int r = 0; r < NR; r++) put_row(r, 4'h0);
    drain_check(1'b0);
    idle(10);
    chk("idle_busy", busy, 1'b0);

    // bubbles between rows 7 and 8
    for (int r = 0; r < 8; r++) put_row(r, 4'h1);
    idle(3);
    for (int r = 8; r < NR; r++) put_row(r, 4'h1);
    drain_check(1'b0);
    idle(10);

    // back-to-back tiles, second one starting as ready returns
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < NR; r++) put_row(r, (t == 0) ? 4'h3 : 4'h5);
      drain_check(1'b0);
    end
    idle(10);

    // overflow while draining, then flush must not clear it
    for (int r = 0; r < NR; r++) put_row(r, 4'h9);
    drain_check(1'b1);
    chk("ovf_sticky", ovf, 1'b1);
    idle(10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ovf_after_flush", ovf, 1'b1);
    idle(3);

    // flush on row 10, then a fresh tile
    for (int r = 0; r < 10; r++) put_row(r, 4'h6);
    bus.row_data = {NL{8'h77}};
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.row_valid = 1'b0;
    clear_exp();
    chk("flush_lane_valid", bus.sa_lane_valid, '0);
    chk("flush_data", bus.sa_data, '0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_ready", bus.row_ready, 1'b1);
    idle(12);
    for (int r = 0; r < NR; r++) put_row(r, 4'hC);
    drain_check(1'b0);
    idle(10);

    // async reset in the middle of DRAIN
    for (int r = 0; r < NR; r++) put_row(r, 4'h2);
    idle(3);
    rst_n = 1'b0;
    clear_exp();
    #1;
    chk("areset_lane_valid", bus.sa_lane_valid, '0);
    chk("areset_data", bus.sa_data, '0);
    chk("areset_done", tile_done, 1'b0);
    chk("areset_busy", busy, 1'b0);
    chk("areset_ovf", ovf, 1'b0);
    chk("areset_ready", bus.row_ready, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", bus.row_ready, 1'b1);
    idle(12);

    for (int k = 0; k < NL; k++) chk($sformatf("lane%0d_leftover", k), lq[k].size(), 0);
    chk("done_leftover", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/systolic_row_skewer.md
Name: systolic_row_skewer

Overview:
- Sits directly downstream of the blocking buffer slaves. Consumes the row stream (one 64-bit matrix row per cycle) that a buffer pushes during its dispatch phase.
- Re-times each row into the diagonal wavefront a systolic array needs: lane k is delayed by k cycles.
- Tracks tile boundaries (N_ROWS rows per tile), drains the skew pipeline after the last row, and reports tile completion to the array controller.

Parameters:
- ELEM_W, 8, bit width of one matrix element.
- N_LANES, 8, elements per row and systolic array columns; ELEM_W*N_LANES equals AXI_DW_g (64).
- N_ROWS, 16, rows per tile; equals the buffer depth.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- flush_i  in  1  synchronous clear of pipeline, counters and FSM.
- row_valid_i  in  1  a row is presented this cycle.
- row_data_i  in  ELEM_W*N_LANES  row; lane k is bits [k*ELEM_W +: ELEM_W].
- row_ready_o  out  1  skewer accepts a row this cycle.
- sa_data_o  out  ELEM_W*N_LANES  skewed lane data to the array.
- sa_lane_valid_o  out  N_LANES  per-lane valid qualifying sa_data_o.
- tile_done_o  out  1  one-cycle pulse when the last element of a tile leaves lane N_LANES-1.
- busy_o  out  1  high when the FSM is not IDLE or any lane is valid.
- overflow_o  out  1  sticky; row_valid_i was seen while row_ready_o=0.

Behaviour:
- Reset (async, rst_n_i=0):
  - All outputs 0, except row_ready_o=1.
  - Pipeline registers, row counter and drain counter cleared; FSM in IDLE.
- Accept condition: accept = row_valid_i & row_ready_o.
- FSM states:
  - IDLE: row_ready_o=1. On accept, go to STREAM with row_cnt=1.
  - STREAM: row_ready_o=1. Each accept increments row_cnt. An accept with row_cnt==N_ROWS-1 goes to DRAIN with drain_cnt=N_LANES-1. Bubbles (no valid) are allowed and propagate as lane-valid 0.
  - DRAIN: row_ready_o=0. drain_cnt decrements each cycle; at drain_cnt==1 go to IDLE. The state lasts N_LANES-1 cycles.
- Skew pipeline:
  - Lane k has k+1 register stages, each holding data and valid.
  - An element of lane k accepted at edge T appears on sa_data_o/sa_lane_valid_o[k] in cycle T+1+k.
  - Lane 0 latency is 1 cycle.
  - Lanes whose valid bit is 0 drive data 0; never drive stale data.
- Tile completion: when the last tile row is accepted at edge T, tile_done_o=1 for exactly cycle T+N_LANES. This coincides with sa_lane_valid_o[N_LANES-1]=1 for that row.
- Back-to-back tiles:
  - row_ready_o returns high in cycle T+N_LANES.
  - A new tile's first row accepted in that cycle overlaps the old tile's final lane output. Both are legal and the values stay distinct per lane.
- Overflow: row_valid_i=1 while row_ready_o=0 sets overflow_o. The row is dropped and no state changes. Only reset clears overflow_o; flush_i does not.
- flush_i:
  - Highest synchronous priority.
  - Next cycle: all lane valids 0, data 0, FSM IDLE, counters 0.
  - A tile_done_o pending in the pipeline is suppressed.
- Counter widths:
  - row_cnt is $clog2(N_ROWS+1) bits.
  - drain_cnt is $clog2(N_LANES) bits, minimum 1.
  - No wrap: counters reset on every tile boundary.
- N_LANES==1: DRAIN is skipped (IDLE directly after last row), and tile_done_o occurs at T+1.
- Async reset mid-tile: everything clears immediately; no tile_done_o is produced for the partial tile.

Decomposition:
- Shared package systolic_pkg holds:
  - skewer_state_t enum {IDLE, STREAM, DRAIN}.
  - Default constants ELEM_W, N_LANES, N_ROWS, shared with blocking_buffer_slv's 16-row depth.
- One sub-module: skew_delay_line, parameterised by DEPTH and W. It is a valid+data shift register with synchronous clear, instantiated once per lane with DEPTH=k+1 via a generate loop.

Test Plan:
- Reset then 16 consecutive rows, lane k of row r = {r[3:0],k[3:0]}. Expect:
  - Cycle T0+1+k+r: sa_lane_valid_o[k]=1 with value {r,k}.
  - tile_done_o only at T0+15+8.
  - row_ready_o low for exactly 7 cycles.
- Rows 0-7, 3 bubble cycles, rows 8-15 → bubbles appear as diagonal zeros with lane valid 0; tile_done_o still 8 cycles after row 15 is accepted.
- Two tiles back-to-back, the second starting the first cycle row_ready_o=1 → exactly two tile_done_o pulses 23 cycles apart; no data corruption on lane 7 during the overlap.
- row_valid_i held high during DRAIN → overflow_o=1 from the next cycle; the dropped row never appears at the outputs; overflow_o survives flush_i.
- flush_i asserted at row 10 → next cycle all valids 0, busy_o=0, no tile_done_o; a fresh 16-row tile then completes normally.
- rst_n_i pulsed low asynchronously mid-DRAIN → outputs clear without waiting for a clock edge; row_ready_o=1 after release.
